if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Holds the PC and looks it up in a direct-mapped instruction cache.
- On a miss, fetches the 32-bit word from the memory controller over a req/ready handshake.
- Drives the IF/ID outputs, and raises if_stall into the stall controller while a miss is pending. It obeys the 6-bit stall_state vector that the stall controller returns.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/icache_dm.sv | 55 +++++
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    // Bit positions inside the stall controller's stall_state vector.
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    // IDLE: looking up the PC every cycle. MISS: waiting on the memory controller.
    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache.
// Lookup is purely combinational; a fill written this cycle is seen next cycle.
module icache_dm
    import if_stage_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:2] lookup_addr,
    output logic              hit,
    output logic [INST_W-1:0] word,
    input  logic              fill_en,
    input  logic [ADDR_W-1:2] fill_addr,
    input  logic [INST_W-1:0] fill_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [INST_W-1:0] data [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = lookup_addr[IDX_W+1:2];
    assign rd_tag = lookup_addr[ADDR_W-1:IDX_W+2];
    assign wr_idx = fill_addr[IDX_W+1:2];
    assign wr_tag = fill_addr[ADDR_W-1:IDX_W+2];

    assign hit  = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign word = data[rd_idx];

    // Valid bits are the only cache state that must be cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[wr_idx] <= TRUE;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, icache lookup, miss FSM and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ICACHE_IDX_W = 7,
    parameter logic [ADDR_W-1:0] RESET_PC     = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_state,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              if_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [INST_W-1:0] mem_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic              hit;
    logic              latch_req;
    logic              fill_en;
    logic [INST_W-1:0] cache_word;
    logic              stall_unused;

    // Upper stall bits steer later stages; fetch only looks at PC/IF/ID holds.
    assign stall_unused = ^stall_state[5:3];

    // The fill always targets the latched request, even if the PC was redirected.
    icache_dm #(.IDX_W(ICACHE_IDX_W)) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (pc[ADDR_W-1:2]),
        .hit         (hit),
        .word        (cache_word),
        .fill_en     (fill_en),
        .fill_addr   (req_addr[ADDR_W-1:2]),
        .fill_data   (mem_inst)
    );

    assign mem_addr = req_addr;

    // Miss FSM next state and outputs: launch on a plain miss, retire on mem_ready.
    always_comb begin
        state_nxt = state;
        latch_req = FALSE;
        fill_en   = FALSE;
        mem_req   = FALSE;
        if_stall  = FALSE;
        case (state)
            IDLE: begin
                if_stall = !hit;
                // A redirect this cycle makes the current miss wrong-path: skip it.
                if (!hit && !jump_flag) begin
                    latch_req = TRUE;
                    state_nxt = MISS;
                end
            end
            MISS: begin
                mem_req  = TRUE;
                if_stall = TRUE;
                if (mem_ready) begin
                    fill_en   = TRUE;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Request address is captured once and held for the whole miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           req_addr <= '0;
        else if (latch_req) req_addr <= pc;
    end

    // PC: redirect beats everything; otherwise advance only on a hit without PC hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  pc <= RESET_PC;
        else if (jump_flag)                        pc <= jump_addr;
        else if (!stall_state[STALL_PC] && hit)    pc <= pc + 32'd4;
    end

    // IF/ID register: flush on redirect, freeze on ID hold, bubble on IF hold or miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= FALSE;
        end else if (jump_flag) begin
            if_valid <= FALSE;
        end else if (!stall_state[STALL_ID]) begin
            if (stall_state[STALL_IF]) begin
                if_valid <= FALSE;
            end else if (hit) begin
                if_pc    <= pc;
                if_inst  <= cache_word;
                if_valid <= TRUE;
            end else begin
                if_valid <= FALSE;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized redirects/stalls,
// with a memory responder and a delivery scoreboard.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int IDX_W = 7;
    localparam int LINES = 1 << IDX_W;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_state;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        if_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int tests  = 0;
    int fails  = 0;
    int nreq   = 0;
    int ndeliv = 0;
    int mem_lat = 3;
    bit lat_rand = 1'b0;

    // Scoreboard: PC expected for the next instruction handed to ID.
    logic [31:0] exp_q[$];

    // Reference cache contents: which full word address each line holds.
    bit          ref_v [LINES];
    logic [31:0] ref_a [LINES];

    // Memory responder state.
    bit          m_pend = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_ra   = '0;

    if_stage #(.ICACHE_IDX_W(IDX_W), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_state (stall_state),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .if_stall    (if_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_inst    (mem_inst),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program image: address 0 holds a NOP (addi x0,x0,0).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        int i;
        i = int'(a[IDX_W+1:2]);
        return ref_v[i] && (ref_a[i][31:IDX_W+2] == a[31:IDX_W+2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Memory controller: answers each request after a latency, and verifies
    // that only genuinely uncached words are fetched and the address is stable.
    initial begin : memory
        int i;
        mem_ready = 1'b0;
        mem_inst  = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!rst) begin
                m_pend = 1'b0;
                for (int k = 0; k < LINES; k++) ref_v[k] = 1'b0;
            end else if (mem_req) begin
                if (!m_pend) begin
                    m_pend = 1'b1;
                    m_ra   = mem_addr;
                    nreq++;
                    m_cnt  = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
                    chkb("req_is_miss", ref_hit(m_ra), 1'b0);
                end else begin
                    chk("mem_addr_stable", mem_addr, m_ra);
                end
                if (m_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_inst  = mem_word(m_ra);
                    m_pend    = 1'b0;
                    i = int'(m_ra[IDX_W+1:2]);
                    ref_v[i] = 1'b1;
                    ref_a[i] = m_ra;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Delivery monitor: every new valid instruction must be the next PC of
    // the program stream (sequential, or the latest redirect target).
    initial begin : monitor
        logic        st2;
        logic        jf;
        logic [31:0] ja;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            st2 = stall_state[STALL_ID];
            jf  = jump_flag;
            ja  = jump_addr;
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                exp_q.push_back(32'h0);
            end else if (jf) begin
                exp_q.delete();
                exp_q.push_back(ja);
            end else if (if_valid && !st2) begin
                ndeliv++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL deliver: pc %h with nothing expected", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", if_pc, e);
                    chk("deliver_inst", if_inst, mem_word(e));
                    exp_q.push_back(e + 32'd4);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        int d0;
        int r;
        rst = 1'b0;
        stall_state = '0;
        jump_flag = 1'b0;
        jump_addr = '0;
        repeat (3) @(negedge clk);

        // Cold start: first fetch misses, one cycle to request, then fill and hit.
        rst = 1'b1;
        chkb("rst_if_valid", if_valid, 1'b0);
        chkb("rst_mem_req", mem_req, 1'b0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chkb("cold_if_stall", if_stall, 1'b1);
        @(negedge clk);
        chkb("cold_mem_req", mem_req, 1'b1);
        chk("cold_mem_addr", mem_addr, 32'h0);
        n = 0;
        while (mem_req && n < 50) begin @(negedge clk); n++; end
        chkb("cold_req_done", mem_req, 1'b0);
        chkb("fill_if_stall", if_stall, 1'b0);
        chkb("fill_if_valid", if_valid, 1'b0);
        @(negedge clk);
        chk("first_if_pc", if_pc, 32'h0);
        chk("first_if_inst", if_inst, 32'h0000_0013);
        chkb("first_if_valid", if_valid, 1'b1);
        chk("first_pc", dut.pc, 32'h4);

        // Warm lines 0..16, then loop 0,4,8 with the redirect issued at 12.
        n = 0;
        while (!(nreq >= 5 && !mem_req) && n < 300) begin @(negedge clk); n++; end
        chkb("warm_done", mem_req, 1'b0);
        d0 = ndeliv;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 4; k++) begin
                jump_flag = (k == 0);
                jump_addr = 32'h0;
                chkb("loop_if_stall", if_stall, 1'b0);
                chkb("loop_mem_req", mem_req, 1'b0);
                @(negedge clk);
            end
        end
        jump_flag = 1'b0;

        // Full hold, then PC+IF hold.
        stall_state = 6'b000111;
        @(negedge clk);
        @(negedge clk);
        chk("hold_pc", dut.pc, 32'hC);
        chk("hold_if_pc", if_pc, 32'h8);
        chkb("hold_if_valid", if_valid, 1'b1);
        chk("loop_deliveries", 32'(ndeliv - d0), 32'd9);
        stall_state = 6'b000011;
        @(negedge clk);
        chk("bubble_pc", dut.pc, 32'hC);
        chkb("bubble_if_valid", if_valid, 1'b0);
        stall_state = 6'b000000;
        @(negedge clk);
        chk("resume_if_pc", if_pc, 32'hC);
        chkb("resume_if_valid", if_valid, 1'b1);

        // Redirect while missing on pc=8: request for 8 completes, then 0x100.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mem_lat = 4;
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 200) begin @(negedge clk); n++; end
        chkb("miss8_seen", mem_req, 1'b1);
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        @(negedge clk);
        jump_flag = 1'b0;
        chk("jump_pc", dut.pc, 32'h100);
        n = 0;
        while (mem_req && n < 50) begin
            chk("miss8_addr_held", mem_addr, 32'h8);
            chkb("miss8_bubble", if_valid, 1'b0);
            @(negedge clk);
            n++;
        end
        chkb("miss8_done", mem_req, 1'b0);
        chkb("post_fill_valid", if_valid, 1'b0);
        @(negedge clk);
        chkb("req100", mem_req, 1'b1);
        chk("req100_addr", mem_addr, 32'h100);
        chkb("req100_bubble", if_valid, 1'b0);
        n = 0;
        while (!if_valid && n < 50) begin @(negedge clk); n++; end
        chkb("jump_target_valid", if_valid, 1'b1);
        chk("jump_target_pc", if_pc, 32'h100);
        jump_flag = 1'b1;
        jump_addr = 32'h8;
        @(negedge clk);
        chkb("line8_filled", if_stall, 1'b0);

        // Conflict: 0x200 evicts line 0, so a later fetch of 0 misses again.
        jump_addr = 32'h200;
        @(negedge clk);
        jump_flag = 1'b0;
        n = 0;
        while (!(if_valid && if_pc == 32'h200) && n < 100) begin @(negedge clk); n++; end
        chk("evictor_pc", if_pc, 32'h200);
        jump_flag = 1'b1;
        jump_addr = 32'h0;
        @(negedge clk);
        jump_flag = 1'b0;
        chkb("evict_if_stall", if_stall, 1'b1);
        n = 0;
        while (!(mem_req && mem_addr == 32'h0) && n < 50) begin @(negedge clk); n++; end
        chkb("refetch0_req", mem_req, 1'b1);
        chk("refetch0_addr", mem_addr, 32'h0);

        // Random redirects, stalls (including ignored upper bits) and latencies.
        lat_rand = 1'b1;
        d0 = ndeliv;
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(0, 9));
            stall_state[2:0] = (r < 6) ? 3'b000 : ((r < 8) ? 3'b011 : 3'b111);
            stall_state[5:3] = 3'($urandom_range(0, 7));
            jump_flag = ($urandom_range(0, 9) == 0);
            jump_addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2);
            @(negedge clk);
        end
        jump_flag = 1'b0;
        stall_state = '0;
        chkb("random_progress", (ndeliv - d0) > 100, 1'b1);

        // Asynchronous reset in the middle of a miss.
        n = 0;
        while (!mem_req && n < 100) begin @(negedge clk); n++; end
        chkb("arst_pre_req", mem_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chkb("arst_mem_req", mem_req, 1'b0);
        chkb("arst_if_valid", if_valid, 1'b0);
        chk("arst_pc", dut.pc, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chkb("arst_if_stall", if_stall, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
